// File: rtl/mem_writeback_if.sv
// Data-memory request/grant/response bus.
// master = LSU side, slave = memory side.
interface mem_writeback_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_writeback.sv
// Memory/writeback stage: load/store bus sequencing,
// load extension and register-file writeback.
module mem_writeback (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     PC_ppl,
  input  logic [31:0]     ALU_ppl,
  input  logic [31:0]     rdata2_forwarded_ppl,
  input  logic [31:0]     instruction_ppl,
  mem_writeback_if.master dmem,
  output logic [31:0]     wdata,
  output logic            reg_wr,
  output logic            lsu_stall,
  output logic            lsu_fault
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_REG   = 5'b01100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RSP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] load_q;

  logic [4:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [1:0]  a;
  logic        valid;
  logic        is_load;
  logic        is_store;
  logic        f3_ok;
  logic        misalign;
  logic        fault;
  logic        mem_op;
  logic        link_wb;
  logic        alu_wb;
  logic [31:0] rsh;
  logic [31:0] ld_ext;

  assign op    = instruction_ppl[6:2];
  assign f3    = instruction_ppl[14:12];
  assign rd    = instruction_ppl[11:7];
  assign a     = ALU_ppl[1:0];
  assign valid = instruction_ppl[1:0] == 2'b11;

  assign is_load  = valid && op == OP_LOAD;
  assign is_store = valid && op == OP_STORE;
  assign link_wb  = valid && (op == OP_JAL || op == OP_JALR);
  assign alu_wb   = valid && (op == OP_IMM || op == OP_REG ||
                              op == OP_LUI || op == OP_AUIPC);

  assign f3_ok = is_load
               ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               : (f3 inside {3'b000, 3'b001, 3'b010});

  assign misalign = (f3[1:0] == 2'b01 && a[0]) ||
                    (f3[1:0] == 2'b10 && a != 2'b00);

  assign fault  = (is_load || is_store) && (!f3_ok || misalign);
  assign mem_op = (is_load || is_store) && !fault;

  // Address, direction and store lanes derive only from held inputs,
  // so they stay stable while the request waits for a grant.
  assign dmem.dmem_addr = {ALU_ppl[31:2], 2'b00};
  assign dmem.dmem_we   = is_store;

  // Store byte enables and lane-replicated data.
  always_comb begin
    dmem.dmem_be    = 4'b1111;
    dmem.dmem_wdata = rdata2_forwarded_ppl;
    unique case (1'b1)
      f3[1:0] == 2'b00: begin
        dmem.dmem_be    = 4'b0001 << a;
        dmem.dmem_wdata = {4{rdata2_forwarded_ppl[7:0]}};
      end
      f3[1:0] == 2'b01: begin
        dmem.dmem_be    = 4'b0011 << {a[1], 1'b0};
        dmem.dmem_wdata = {2{rdata2_forwarded_ppl[15:0]}};
      end
      default: ;
    endcase
  end

  assign rsh = dmem.dmem_rdata >> {a, 3'b000};

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    ld_ext = dmem.dmem_rdata;
    unique case (1'b1)
      f3 == 3'b000: ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      f3 == 3'b001: ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      f3 == 3'b100: ld_ext = {24'd0, rsh[7:0]};
      f3 == 3'b101: ld_ext = {16'd0, rsh[15:0]};
      default: ;
    endcase
  end

  // State register and captured load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT_RSP && dmem.dmem_rvalid)
        load_q <= ld_ext;
    end
  end

  // Next state, bus request, stall and writeback.
  always_comb begin
    state_d       = state_q;
    dmem.dmem_req = 1'b0;
    lsu_stall     = 1'b0;
    lsu_fault     = 1'b0;
    reg_wr        = 1'b0;
    wdata         = '0;
    unique case (state_q)
      IDLE: begin
        if (fault) begin
          lsu_fault = 1'b1;
        end else if (mem_op) begin
          dmem.dmem_req = 1'b1;
          lsu_stall     = 1'b1;
          if (dmem.dmem_gnt)
            state_d = is_store ? DONE : WAIT_RSP;
        end else begin
          unique case (1'b1)
            link_wb: begin
              wdata  = PC_ppl + 32'd4;
              reg_wr = rd != 5'd0;
            end
            alu_wb: begin
              wdata  = ALU_ppl;
              reg_wr = rd != 5'd0;
            end
            default: ;
          endcase
        end
      end
      WAIT_RSP: begin
        lsu_stall = 1'b1;
        if (dmem.dmem_rvalid)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (is_load) begin
          wdata  = load_q;
          reg_wr = rd != 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset squashes any in-flight side effects immediately.
    if (rst) begin
      dmem.dmem_req = 1'b0;
      lsu_stall     = 1'b0;
      lsu_fault     = 1'b0;
      reg_wr        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Bench for mem_writeback: vector table, directed
// multi-cycle sequences and randomized transactions.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_ppl, alu_ppl, rs2_ppl, instr;
  logic [31:0] wdata;
  logic        reg_wr, lsu_stall, lsu_fault;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_writeback_if bus ();

  mem_writeback dut (
    .clk                  (clk),
    .rst                  (rst),
    .PC_ppl               (pc_ppl),
    .ALU_ppl              (alu_ppl),
    .rdata2_forwarded_ppl (rs2_ppl),
    .instruction_ppl      (instr),
    .dmem                 (bus),
    .wdata                (wdata),
    .reg_wr               (reg_wr),
    .lsu_stall            (lsu_stall),
    .lsu_fault            (lsu_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ins;
    logic        wr;
    logic        chk_wd;
    logic [31:0] wd;
    logic        flt;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op,
                                     input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'd0, f3, rd, op, 2'b11};
  endfunction

  // Reference: extended load value from the spec's lane rules.
  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] addr,
                                         input logic [31:0] r);
    int unsigned lane = addr % 4;
    int unsigned b = (r >> (8 * lane)) % 256;
    int unsigned h = (r >> (16 * (lane / 2))) % 65536;
    case (f3)
      3'd0: return b >= 128 ? b + 32'hFFFFFF00 : b;
      3'd1: return h >= 32768 ? h + 32'hFFFF0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return r;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] addr);
    int unsigned lane = addr % 4;
    case (f3)
      3'd0: return 4'(1 << lane);
      3'd1: return 4'(3 << (lane / 2 * 2));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_sd(input logic [2:0] f3,
                                       input logic [31:0] d);
    case (f3)
      3'd0: return (d % 256) * 32'h01010101;
      3'd1: return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  // Drive one load/store from issue to retirement, checking each cycle.
  task automatic run_mem(input string nm, input bit st,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] rdat, input int gd,
                         input int rvd);
    logic [31:0] ea;
    ea = alu & 32'hFFFFFFFC;
    instr   = mk(st ? 5'b01000 : 5'b00000, f3, rd);
    alu_ppl = alu;
    rs2_ppl = rs2;
    pc_ppl  = $urandom();
    for (int c = 0; c <= gd; c++) begin
      bus.dmem_gnt = (c == gd);
      #1;
      chk({nm, " req"}, 32'(bus.dmem_req), 32'd1);
      chk({nm, " stall"}, 32'(lsu_stall), 32'd1);
      chk({nm, " addr"}, bus.dmem_addr, ea);
      chk({nm, " we"}, 32'(bus.dmem_we), 32'(st));
      chk({nm, " wr_busy"}, 32'(reg_wr), 32'd0);
      if (st) begin
        chk({nm, " be"}, 32'(bus.dmem_be), 32'(m_be(f3, alu)));
        chk({nm, " sdata"}, bus.dmem_wdata, m_sd(f3, rs2));
      end
      @(posedge clk); #1;
    end
    bus.dmem_gnt = 1'b0;
    if (!st) begin
      for (int k = 0; k <= rvd; k++) begin
        bus.dmem_rvalid = (k == rvd);
        bus.dmem_rdata  = (k == rvd) ? rdat : ~rdat;
        #1;
        chk({nm, " wait_req"}, 32'(bus.dmem_req), 32'd0);
        chk({nm, " wait_stall"}, 32'(lsu_stall), 32'd1);
        chk({nm, " wait_wr"}, 32'(reg_wr), 32'd0);
        @(posedge clk); #1;
      end
    end
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = $urandom();
    #1;
    chk({nm, " done_stall"}, 32'(lsu_stall), 32'd0);
    chk({nm, " done_req"}, 32'(bus.dmem_req), 32'd0);
    chk({nm, " done_wr"}, 32'(reg_wr), 32'(!st && rd != 5'd0));
    if (!st && rd != 5'd0)
      chk({nm, " done_wdata"}, wdata, m_load(f3, alu, rdat));
    @(posedge clk); #1;
    instr = '0;
  endtask

  vec_t        vecs[$];
  logic [2:0]  lf [5];
  logic [4:0]  nops [7];

  initial begin
    rst = 1'b1;
    pc_ppl = '0; alu_ppl = '0; rs2_ppl = '0; instr = '0;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
    lf   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    nops = '{5'b00100, 5'b01100, 5'b01101, 5'b00101,
             5'b11011, 5'b11001, 5'b11000};

    vecs.push_back('{"addi", 0, 32'h1234, mk(5'b00100, 3'd0, 5'd5), 1, 1, 32'h1234, 0});
    vecs.push_back('{"addi_x0", 0, 32'h1234, mk(5'b00100, 3'd0, 5'd0), 0, 0, 0, 0});
    vecs.push_back('{"jal", 32'h100, 32'h55, mk(5'b11011, 3'd0, 5'd1), 1, 1, 32'h104, 0});
    vecs.push_back('{"jalr_wrap", 32'hFFFFFFFC, 0, mk(5'b11001, 3'd0, 5'd31), 1, 1, 0, 0});
    vecs.push_back('{"lui", 0, 32'hDEADB000, mk(5'b01101, 3'd0, 5'd3), 1, 1, 32'hDEADB000, 0});
    vecs.push_back('{"bubble", 32'h40, 32'h99, 0, 0, 1, 0, 0});
    vecs.push_back('{"branch", 0, 32'h8, mk(5'b11000, 3'd1, 5'd7), 0, 0, 0, 0});
    vecs.push_back('{"compressed", 0, 32'h8, mk(5'b00100, 3'd0, 5'd7) & 32'hFFFFFFFD, 0, 0, 0, 0});
    vecs.push_back('{"unknown_op", 0, 32'h8, mk(5'b11111, 3'd0, 5'd7), 0, 0, 0, 0});
    vecs.push_back('{"lw_misal", 0, 32'h3001, mk(5'b00000, 3'd2, 5'd4), 0, 0, 0, 1});
    vecs.push_back('{"ld_f3_011", 0, 32'h3000, mk(5'b00000, 3'd3, 5'd4), 0, 0, 0, 1});
    vecs.push_back('{"lh_misal", 0, 32'h0001, mk(5'b00000, 3'd1, 5'd4), 0, 0, 0, 1});
    vecs.push_back('{"sw_misal", 0, 32'h0002, mk(5'b01000, 3'd2, 5'd0), 0, 0, 0, 1});
    vecs.push_back('{"st_f3_100", 0, 32'h0000, mk(5'b01000, 3'd4, 5'd0), 0, 0, 0, 1});

    // Reset state.
    @(posedge clk); #1;
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_stall", 32'(lsu_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_req", 32'(bus.dmem_req), 32'd0);
    chk("post_rst_wr", 32'(reg_wr), 32'd0);
    chk("post_rst_fault", 32'(lsu_fault), 32'd0);
    chk("post_rst_wdata", wdata, 32'd0);

    // Single-cycle vectors.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      pc_ppl = vecs[i].pc; alu_ppl = vecs[i].alu; instr = vecs[i].ins;
      #1;
      chk({vecs[i].name, " reg_wr"}, 32'(reg_wr), 32'(vecs[i].wr));
      chk({vecs[i].name, " fault"}, 32'(lsu_fault), 32'(vecs[i].flt));
      chk({vecs[i].name, " req"}, 32'(bus.dmem_req), 32'd0);
      chk({vecs[i].name, " stall"}, 32'(lsu_stall), 32'd0);
      if (vecs[i].chk_wd)
        chk({vecs[i].name, " wdata"}, wdata, vecs[i].wd);
    end
    // Fault is a pulse: gone once the next instruction arrives.
    @(posedge clk); #1;
    instr = '0;
    #1;
    chk("fault_pulse_end", 32'(lsu_fault), 32'd0);
    @(posedge clk); #1;

    // Directed multi-cycle sequences.
    run_mem("lb", 0, 3'd0, 5'd6, 32'h1003, 0, 32'h80FFFF00, 0, 0);
    run_mem("lbu", 0, 3'd4, 5'd6, 32'h1003, 0, 32'h80FFFF00, 0, 0);
    run_mem("sh_wait3", 1, 3'd1, 5'd0, 32'h2002, 32'h0000BEEF, 0, 3, 0);
    run_mem("lw_x0", 0, 3'd2, 5'd0, 32'h10, 0, 32'hCAFEF00D, 1, 2);

    // Reset while waiting for a load response; the late rvalid is dropped.
    instr = mk(5'b00000, 3'd2, 5'd9); alu_ppl = 32'h4000;
    bus.dmem_gnt = 1'b1;
    #1;
    chk("rst_seq req", 32'(bus.dmem_req), 32'd1);
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0; rst = 1'b1;
    #1;
    chk("rst_seq req_in_rst", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; instr = '0;
    bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h12345678;
    #1;
    chk("rst_seq late_wr", 32'(reg_wr), 32'd0);
    chk("rst_seq late_stall", 32'(lsu_stall), 32'd0);
    chk("rst_seq late_req", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    #1;
    chk("rst_seq after_wr", 32'(reg_wr), 32'd0);
    chk("rst_seq after_stall", 32'(lsu_stall), 32'd0);
    @(posedge clk); #1;
    // Back in IDLE: a fresh load must request immediately.
    run_mem("post_rst_lw", 0, 3'd2, 5'd9, 32'h4000, 0, 32'hA5A5A5A5, 0, 0);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      int unsigned kind = $urandom_range(2);
      logic [31:0] r  = $urandom();
      logic [31:0] d  = $urandom();
      logic [4:0]  rd = 5'($urandom_range(31));
      if (kind == 0) begin
        logic [2:0] f3 = lf[$urandom_range(4)];
        if (f3[1:0] == 2'b10) r = r & 32'hFFFFFFFC;
        if (f3[1:0] == 2'b01) r = r & 32'hFFFFFFFE;
        run_mem("rnd_load", 0, f3, rd, r, 0, d,
                int'($urandom_range(3)), int'($urandom_range(2)));
      end else if (kind == 1) begin
        logic [2:0] f3 = 3'($urandom_range(2));
        if (f3 == 3'd2) r = r & 32'hFFFFFFFC;
        if (f3 == 3'd1) r = r & 32'hFFFFFFFE;
        run_mem("rnd_store", 1, f3, rd, r, d, 0,
                int'($urandom_range(3)), 0);
      end else begin
        logic [4:0]  op = nops[$urandom_range(6)];
        logic [31:0] pc = $urandom();
        logic        ewr;
        logic [31:0] ewd;
        ewr = (op != 5'b11000) && (rd != 5'd0);
        ewd = (op == 5'b11011 || op == 5'b11001) ? pc + 4 : r;
        instr = mk(op, 3'd0, rd); pc_ppl = pc; alu_ppl = r;
        #1;
        chk("rnd_alu wr", 32'(reg_wr), 32'(ewr));
        if (ewr) chk("rnd_alu wdata", wdata, ewd);
        chk("rnd_alu stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
